// File: rtl/ps2_keyboard_pkg.sv
// Shared definitions for the PS/2 keyboard receiver and the memory mapper.
//   rx_state_e     : receive FSM states
//   *_BIT          : bit positions of the status flags in the keyboard word
//   KBD_ADDR       : CPU address that returns the keyboard word
//   kbd_word()     : assembles the 16-bit status/data word
package ps2_keyboard_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } rx_state_e;

  localparam int unsigned AVAIL_BIT = 15;
  localparam int unsigned OVF_BIT   = 14;
  localparam int unsigned PERR_BIT  = 13;

  localparam logic [15:0] KBD_ADDR = 16'hFE00;

  // Data byte reads as 0x00 whenever the FIFO is empty.
  function automatic logic [15:0] kbd_word(input logic       avail,
                                           input logic       ovf,
                                           input logic       perr,
                                           input logic [7:0] head);
    logic [15:0] w;
    w            = '0;
    w[AVAIL_BIT] = avail;
    w[OVF_BIT]   = ovf;
    w[PERR_BIT]  = perr;
    w[7:0]       = avail ? head : 8'h00;
    return w;
  endfunction

endpackage

// File: rtl/keyboard_fifo.sv
// Synchronous scancode FIFO.
//   push/wdata : write one entry (caller guarantees not full, or popping)
//   pop        : remove the head (caller guarantees not empty)
//   head       : current head entry (valid when !empty)
//   full/empty : occupancy flags
module keyboard_fifo #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q,  count_d;

  // NOTE: storage has no reset; every entry is written before the count
  // lets it be read, so resetting it would only cost routing.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= wdata;
  end

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    count_d  = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + (PTR_W+1)'(1);
      2'b01:   count_d = count_q - (PTR_W+1)'(1);
      default: count_d = count_q;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop
  // samples the pre-edge values of the others.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign head  = mem_q[rd_ptr_q];
  assign full  = (count_q == (PTR_W+1)'(DEPTH));
  assign empty = (count_q == '0);

endmodule

// File: rtl/ps2_keyboard.sv
// PS/2 keyboard receiver with scancode FIFO.
//   clk, rst_n   : system clock, async active-low reset
//   ps2Clk       : raw PS/2 clock line (asynchronous)
//   ps2Data      : raw PS/2 data line (asynchronous)
//   readStrobe   : one-cycle pulse per completed CPU read of the keyboard word
//   keyboardData : {AVAIL, OVF, PERR, 5'b0, head scancode}
module ps2_keyboard
  import ps2_keyboard_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH     = 8,
  parameter int unsigned SYNC_STAGES    = 2,
  parameter int unsigned TIMEOUT_CYCLES = 50000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ps2Clk,
  input  logic        ps2Data,
  input  logic        readStrobe,
  output logic [15:0] keyboardData
);

  localparam int unsigned WD_W = $clog2(TIMEOUT_CYCLES + 1);

  // ---------------------------------------------------------------- sync
  logic [SYNC_STAGES-1:0] clk_sync_q,  clk_sync_d;
  logic [SYNC_STAGES-1:0] data_sync_q, data_sync_d;
  logic                   clk_prev_q,  clk_prev_d;
  logic                   fall;
  logic                   data_s;

  always_comb begin
    clk_sync_d  = {clk_sync_q[SYNC_STAGES-2:0],  ps2Clk};
    data_sync_d = {data_sync_q[SYNC_STAGES-2:0], ps2Data};
    clk_prev_d  = clk_sync_q[SYNC_STAGES-1];
  end

  // Lines idle high, so the synchronisers reset to 1 to avoid a false edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_sync_q  <= '1;
      data_sync_q <= '1;
      clk_prev_q  <= 1'b1;
    end else begin
      clk_sync_q  <= clk_sync_d;
      data_sync_q <= data_sync_d;
      clk_prev_q  <= clk_prev_d;
    end
  end

  assign fall   = clk_prev_q & ~clk_sync_q[SYNC_STAGES-1];
  assign data_s = data_sync_q[SYNC_STAGES-1];

  // ---------------------------------------------------------- receive FSM
  rx_state_e        state_q,   state_d;
  logic [2:0]       bit_cnt_q, bit_cnt_d;
  logic [7:0]       shift_q,   shift_d;
  logic             parity_q,  parity_d;
  logic [WD_W-1:0]  wd_q,      wd_d;
  logic             push_req;
  logic             frame_err;

  // NOTE: every combinational output gets a default first so no path
  // through the case leaves it unassigned and infers a latch.
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    parity_d  = parity_q;
    wd_d      = '0;
    push_req  = 1'b0;
    frame_err = 1'b0;

    if (state_q != IDLE) wd_d = fall ? '0 : wd_q + WD_W'(1);

    unique case (state_q)
      IDLE: begin
        if (fall && !data_s) begin
          state_d   = DATA;
          bit_cnt_d = 3'd0;
        end
      end
      DATA: begin
        if (fall) begin
          shift_d   = {data_s, shift_q[7:1]};  // LSB arrives first
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) state_d = PARITY;
        end
      end
      PARITY: begin
        if (fall) begin
          parity_d = data_s;
          state_d  = STOP;
        end
      end
      STOP: begin
        if (fall) begin
          // Odd parity: data bits plus parity bit carry an odd number of ones.
          if (data_s && (^{shift_q, parity_q})) push_req  = 1'b1;
          else                                  frame_err = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // A fall this cycle proves the device is still clocking, so it wins.
    if (state_q != IDLE && !fall && wd_q == WD_W'(TIMEOUT_CYCLES - 1)) begin
      state_d   = IDLE;
      bit_cnt_d = 3'd0;
      wd_d      = '0;
      frame_err = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      parity_q  <= 1'b0;
      wd_q      <= '0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      parity_q  <= parity_d;
      wd_q      <= wd_d;
    end
  end

  // ------------------------------------------------------- FIFO and flags
  logic       fifo_full, fifo_empty;
  logic [7:0] fifo_head;
  logic       pop_req, push_ok;
  logic       ovf_q,  ovf_d;
  logic       perr_q, perr_d;

  // A pop in the same cycle frees the slot, so a push into a full FIFO is
  // only dropped when no read is happening alongside it.
  assign pop_req = readStrobe & ~fifo_empty;
  assign push_ok = push_req & (~fifo_full | pop_req);

  always_comb begin
    ovf_d  = ovf_q;
    perr_d = perr_q;
    if (pop_req) begin
      ovf_d  = 1'b0;
      perr_d = 1'b0;
    end
    if (push_req && fifo_full && !pop_req) ovf_d  = 1'b1;
    if (frame_err)                         perr_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q  <= 1'b0;
      perr_q <= 1'b0;
    end else begin
      ovf_q  <= ovf_d;
      perr_q <= perr_d;
    end
  end

  keyboard_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push_ok),
    .wdata (shift_q),
    .pop   (pop_req),
    .head  (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign keyboardData = kbd_word(~fifo_empty, ovf_q, perr_q, fifo_head);

endmodule
